// File: rtl/ring_client_arbiter.sv
// Shares one ring node client port among NCLIENT local requesters: round-robin
// transmit arbitration with a held word, and an id-steered single-entry receive buffer.
module ring_client_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NCLIENT = 4,
  parameter int CBITS   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCLIENT-1:0]         cl_txreq,
  input  logic [NCLIENT*WIDTH-1:0]   cl_txdata,
  output logic [NCLIENT-1:0]         cl_txack,
  output logic [NCLIENT-1:0]         cl_rxvalid,
  output logic [WIDTH-1:0]           cl_rxdata,
  input  logic [NCLIENT-1:0]         cl_rxack,
  output logic                       node_txvalid,
  output logic [WIDTH-1:0]           node_txdata,
  input  logic                       node_txack,
  input  logic                       node_rxvalid,
  input  logic [WIDTH-1:0]           node_rxdata,
  output logic                       node_rxack,
  output logic [7:0]                 drop_count
);

  localparam int GBITS = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;
  localparam logic [NCLIENT-1:0] CLIENT0 = NCLIENT'(1);

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  // ---------------------------------------------------------------------------
  // Transmit side
  // ---------------------------------------------------------------------------
  tx_state_e             tx_state_q, tx_state_d;
  logic [GBITS-1:0]      grant_q, grant_d;
  logic [GBITS-1:0]      last_grant_q, last_grant_d;
  logic                  node_txvalid_q, node_txvalid_d;
  logic [WIDTH-1:0]      node_txdata_q, node_txdata_d;
  logic [NCLIENT-1:0]    cl_txack_q, cl_txack_d;

  logic [WIDTH-1:0]      tx_words [NCLIENT];
  logic                  pick_found;
  logic [GBITS-1:0]      pick_idx;
  logic [GBITS-1:0]      scan_idx;

  always_comb begin
    for (int i = 0; i < NCLIENT; i++) begin
      tx_words[i] = cl_txdata[i*WIDTH +: WIDTH];
    end
  end

  // Scan starts just past the last completed grant so every requester waits
  // at most NCLIENT-1 words.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 1; k <= NCLIENT; k++) begin
      scan_idx = GBITS'((int'(last_grant_q) + k) % NCLIENT);
      if (!pick_found && cl_txreq[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    tx_state_d     = tx_state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    node_txvalid_d = node_txvalid_q;
    node_txdata_d  = node_txdata_q;
    cl_txack_d     = '0;
    case (tx_state_q)
      TX_IDLE: begin
        if (pick_found) begin
          grant_d        = pick_idx;
          node_txdata_d  = tx_words[pick_idx];
          node_txvalid_d = 1'b1;
          tx_state_d     = TX_SEND;
        end
      end
      TX_SEND: begin
        if (node_txack) begin
          node_txvalid_d = 1'b0;
          cl_txack_d     = CLIENT0 << grant_q;
          last_grant_d   = grant_q;
          tx_state_d     = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_q     <= TX_IDLE;
      grant_q        <= '0;
      last_grant_q   <= GBITS'(NCLIENT - 1);
      node_txvalid_q <= 1'b0;
      node_txdata_q  <= '0;
      cl_txack_q     <= '0;
    end else begin
      tx_state_q     <= tx_state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      node_txvalid_q <= node_txvalid_d;
      node_txdata_q  <= node_txdata_d;
      cl_txack_q     <= cl_txack_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive side
  // ---------------------------------------------------------------------------
  logic [NCLIENT-1:0]    cl_rxvalid_q, cl_rxvalid_d;
  logic [WIDTH-1:0]      cl_rxdata_q, cl_rxdata_d;
  logic                  node_rxack_q, node_rxack_d;
  logic [7:0]            drop_count_q, drop_count_d;

  logic [CBITS-1:0]      rx_id;
  logic [NCLIENT-1:0]    rx_onehot;
  logic                  rx_capture;
  logic                  rx_consume;

  assign rx_id = node_rxdata[WIDTH-1 -: CBITS];

  always_comb begin
    rx_onehot = '0;
    for (int i = 0; i < NCLIENT; i++) begin
      rx_onehot[i] = (rx_id == CBITS'(i));
    end
  end

  // The node still presents the word during the ack cycle, so a capture is
  // blocked there; otherwise a dropped word would be counted twice.
  assign rx_capture = ~|cl_rxvalid_q && node_rxvalid && !node_rxack_q;
  assign rx_consume = |(cl_rxvalid_q & cl_rxack);

  always_comb begin
    cl_rxvalid_d = cl_rxvalid_q;
    cl_rxdata_d  = cl_rxdata_q;
    node_rxack_d = 1'b0;
    drop_count_d = drop_count_q;
    if (rx_consume) begin
      cl_rxvalid_d = '0;
    end else if (rx_capture) begin
      node_rxack_d = 1'b1;
      if (|rx_onehot) begin
        cl_rxvalid_d = rx_onehot;
        cl_rxdata_d  = node_rxdata;
      end else if (drop_count_q != 8'hFF) begin
        drop_count_d = drop_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cl_rxvalid_q <= '0;
      cl_rxdata_q  <= '0;
      node_rxack_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      cl_rxvalid_q <= cl_rxvalid_d;
      cl_rxdata_q  <= cl_rxdata_d;
      node_rxack_q <= node_rxack_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign cl_txack     = cl_txack_q;
  assign node_txvalid = node_txvalid_q;
  assign node_txdata  = node_txdata_q;
  assign cl_rxvalid   = cl_rxvalid_q;
  assign cl_rxdata    = cl_rxdata_q;
  assign node_rxack   = node_rxack_q;
  assign drop_count   = drop_count_q;

  a_rxvalid_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(cl_rxvalid_q));
  a_txack_onehot:   assert property (@(posedge clk) disable iff (!rst) $onehot0(cl_txack_q));
  a_tx_hold:        assert property (@(posedge clk) disable iff (!rst)
                                     (node_txvalid_q && !node_txack) |=> $stable(node_txdata_q));

endmodule

// File: tb/tb_ring_client_arbiter.sv
// Self-checking bench for ring_client_arbiter: vector table, directed corner
// sequences, a drop-path instance with NCLIENT=3 and a randomized model comparison.
module tb_ring_client_arbiter;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int CB = 2;
  localparam int N3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [N-1:0]   cl_txreq, cl_txack, cl_rxvalid, cl_rxack;
  logic [N*W-1:0] cl_txdata;
  logic [W-1:0]   cl_rxdata, node_txdata, node_rxdata;
  logic           node_txvalid, node_txack, node_rxvalid, node_rxack;
  logic [7:0]     drop_count;

  logic [N3-1:0]   cl_txreq3, cl_txack3, cl_rxvalid3, cl_rxack3;
  logic [N3*W-1:0] cl_txdata3;
  logic [W-1:0]    cl_rxdata3, node_txdata3, node_rxdata3;
  logic            node_txvalid3, node_txack3, node_rxvalid3, node_rxack3;
  logic [7:0]      drop_count3;

  ring_client_arbiter #(.WIDTH(W), .NCLIENT(N), .CBITS(CB)) dut (
    .clk(clk), .rst(rst),
    .cl_txreq(cl_txreq), .cl_txdata(cl_txdata), .cl_txack(cl_txack),
    .cl_rxvalid(cl_rxvalid), .cl_rxdata(cl_rxdata), .cl_rxack(cl_rxack),
    .node_txvalid(node_txvalid), .node_txdata(node_txdata), .node_txack(node_txack),
    .node_rxvalid(node_rxvalid), .node_rxdata(node_rxdata), .node_rxack(node_rxack),
    .drop_count(drop_count)
  );

  ring_client_arbiter #(.WIDTH(W), .NCLIENT(N3), .CBITS(CB)) dut3 (
    .clk(clk), .rst(rst),
    .cl_txreq(cl_txreq3), .cl_txdata(cl_txdata3), .cl_txack(cl_txack3),
    .cl_rxvalid(cl_rxvalid3), .cl_rxdata(cl_rxdata3), .cl_rxack(cl_rxack3),
    .node_txvalid(node_txvalid3), .node_txdata(node_txdata3), .node_txack(node_txack3),
    .node_rxvalid(node_rxvalid3), .node_rxdata(node_rxdata3), .node_rxack(node_rxack3),
    .drop_count(drop_count3)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] word;
    logic [N-1:0] exp_valid;
  } rx_vec_t;

  rx_vec_t rx_tab [7];

  // reference-model state for the randomized phase
  bit           m_busy;
  int           m_grant, m_last;
  logic [W-1:0] m_txdata;
  logic [W-1:0] rxq [$];
  logic [N-1:0] p_req, p_clrxack;
  logic [W-1:0] p_data [N];
  logic         p_ntack, p_nv, p_rxack, exp_rxack, exp_txvalid;
  logic [W-1:0] p_nw, head;
  logic [N-1:0] exp_txack, exp_rxv, ev;

  int exp_g, acks, last_cyc, words;
  logic prev_v;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cl_txreq = '0;  cl_txdata = '0;  cl_rxack = '0;
    node_txack = 1'b0; node_rxvalid = 1'b0; node_rxdata = '0;
    cl_txreq3 = '0; cl_txdata3 = '0; cl_rxack3 = '0;
    node_txack3 = 1'b0; node_rxvalid3 = 1'b0; node_rxdata3 = '0;
    tick();
    check("rst_txack",    cl_txack,     '0);
    check("rst_txvalid",  node_txvalid, 0);
    check("rst_txdata",   node_txdata,  0);
    check("rst_rxvalid",  cl_rxvalid,   '0);
    check("rst_rxdata",   cl_rxdata,    0);
    check("rst_rxack",    node_rxack,   0);
    check("rst_drop",     drop_count,   0);
    check("rst3_drop",    drop_count3,  0);
    check("rst3_misc",    {cl_txack3, node_txvalid3, node_txdata3, cl_rxdata3, cl_rxvalid3}, 0);
    rst = 1'b1;
  endtask

  function automatic int rr_pick(input int last_g, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      if (req[(last_g + k) % N]) return (last_g + k) % N;
    end
    return -1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_tab[0] = '{16'h0000, 4'b0001};
    rx_tab[1] = '{16'h3FFF, 4'b0001};
    rx_tab[2] = '{16'h4ABC, 4'b0010};
    rx_tab[3] = '{16'h7FFF, 4'b0010};
    rx_tab[4] = '{16'hBFFF, 4'b0100};
    rx_tab[5] = '{16'hC000, 4'b1000};
    rx_tab[6] = '{16'hFFFF, 4'b1000};

    do_reset();

    // ---- table-driven receive steering ----
    for (int i = 0; i < 7; i++) begin
      node_rxvalid = 1'b1;
      node_rxdata  = rx_tab[i].word;
      tick();
      check("tab_rxack",   node_rxack, 1);
      check("tab_rxvalid", cl_rxvalid, rx_tab[i].exp_valid);
      check("tab_rxdata",  cl_rxdata,  rx_tab[i].word);
      node_rxvalid = 1'b0;
      cl_rxack     = rx_tab[i].exp_valid;
      tick();
      check("tab_rxclr",   cl_rxvalid, 0);
      cl_rxack = '0;
      tick();
    end

    // ---- single send, node acks 3 cycles after valid ----
    do_reset();
    cl_txdata[0*W +: W] = 16'hA5A5;
    cl_txreq = 4'b0001;
    tick();
    check("ss_valid", node_txvalid, 1);
    check("ss_data",  node_txdata,  16'hA5A5);
    check("ss_noack", cl_txack,     0);
    tick();
    check("ss_hold1", {node_txvalid, node_txdata}, {1'b1, 16'hA5A5});
    tick();
    check("ss_hold2", {node_txvalid, node_txdata}, {1'b1, 16'hA5A5});
    node_txack = 1'b1;
    tick();
    node_txack = 1'b0;
    cl_txreq   = '0;
    check("ss_ack",     cl_txack,     4'b0001);
    check("ss_valid_0", node_txvalid, 0);
    tick();
    check("ss_ack_one", cl_txack,     0);

    // ---- round-robin fairness, node acks one cycle after seeing valid ----
    do_reset();
    for (int i = 0; i < N; i++) cl_txdata[i*W +: W] = W'(16'h1000 + i);
    cl_txreq = 4'hF;
    exp_g = 0; acks = 0; last_cyc = 0; prev_v = 1'b0;
    for (int cyc = 0; cyc < 60 && acks < 8; cyc++) begin
      tick();
      if (cl_txack != 0) begin
        ev = 4'b0001 << exp_g;
        check("rr_grant", cl_txack, ev);
        if (acks > 0) check("rr_spacing", cyc - last_cyc, 3);
        last_cyc = cyc;
        exp_g = (exp_g + 1) % N;
        acks++;
        if (acks == 8) cl_txreq = '0;
      end
      node_txack = node_txvalid && prev_v && !node_txack;
      prev_v     = node_txvalid;
    end
    check("rr_count", acks, 8);
    node_txack = 1'b0;
    tick();

    // ---- request withdrawn while granted (last grant was 3) ----
    cl_txdata[2*W +: W] = 16'hBEEF;
    cl_txreq = 4'b0100;
    tick();
    check("wd_data", {node_txvalid, node_txdata}, {1'b1, 16'hBEEF});
    cl_txreq = '0;
    tick();
    check("wd_hold", {node_txvalid, node_txdata}, {1'b1, 16'hBEEF});
    node_txack = 1'b1;
    tick();
    node_txack = 1'b0;
    check("wd_ack",   cl_txack,     4'b0100);
    check("wd_idle",  node_txvalid, 0);
    tick();
    check("wd_noreg", {cl_txack, node_txvalid}, 0);

    // ---- reset in the middle of a send (last grant is 2) ----
    cl_txdata[0*W +: W] = 16'h1111;
    cl_txreq = 4'b0001;
    tick();
    check("mr_valid", {node_txvalid, node_txdata}, {1'b1, 16'h1111});
    rst = 1'b0;
    node_txack = 1'b1;
    cl_txreq = '0;
    tick();
    check("mr_drop",  {node_txvalid, node_txdata}, 0);
    check("mr_noack", cl_txack, 0);
    rst = 1'b1;
    node_txack = 1'b0;
    cl_txdata[1*W +: W] = 16'h2222;
    cl_txdata[3*W +: W] = 16'h3333;
    cl_txreq = 4'b1010;
    tick();
    check("mr_first", {node_txvalid, node_txdata}, {1'b1, 16'h2222});
    check("mr_noack2", cl_txack, 0);
    node_txack = 1'b1;
    tick();
    node_txack = 1'b0;
    check("mr_ack1", cl_txack, 4'b0010);
    cl_txreq = 4'b1000;
    tick();
    check("mr_second", {cl_txack, node_txvalid, node_txdata}, {4'b0000, 1'b1, 16'h3333});
    node_txack = 1'b1;
    tick();
    node_txack = 1'b0;
    cl_txreq = '0;
    check("mr_ack3", cl_txack, 4'b1000);
    tick();

    // ---- receive steering, stall and bubble ----
    node_rxvalid = 1'b1;
    node_rxdata  = 16'h8123;
    tick();
    check("rs_rxack",  node_rxack, 1);
    check("rs_valid",  cl_rxvalid, 4'b0100);
    check("rs_data",   cl_rxdata,  16'h8123);
    node_rxdata = 16'h4001;
    cl_rxack    = 4'b1011;
    tick();
    check("rs_pulse",  node_rxack, 0);
    check("rs_ignore", {cl_rxvalid, cl_rxdata}, {4'b0100, 16'h8123});
    tick();
    check("rs_stall",  node_rxack, 0);
    cl_rxack = 4'b0100;
    tick();
    check("rs_clear",  cl_rxvalid, 0);
    check("rs_bubble", node_rxack, 0);
    cl_rxack = '0;
    tick();
    check("rs_cap2",   node_rxack, 1);
    check("rs_valid2", {cl_rxvalid, cl_rxdata}, {4'b0010, 16'h4001});
    node_rxvalid = 1'b0;
    cl_rxack = 4'b0010;
    tick();
    check("rs_clear2", cl_rxvalid, 0);
    cl_rxack = '0;
    tick();

    // ---- drop path on the NCLIENT=3 instance ----
    words = 0;
    node_rxvalid3 = 1'b1;
    node_rxdata3  = {2'b11, 14'($urandom)};
    cl_rxack3     = 3'b111;
    for (int cyc = 0; cyc < 1000 && words < 300; cyc++) begin
      tick();
      check("dr_rxvalid", cl_rxvalid3, 0);
      if (node_rxack3) begin
        words++;
        check("dr_count", drop_count3, (words > 255) ? 255 : words);
        node_rxdata3 = {2'b11, 14'($urandom)};
      end
    end
    node_rxvalid3 = 1'b0;
    check("dr_words", words, 300);
    check("dr_sat",   drop_count3, 255);
    do_reset();

    // ---- randomized traffic against the reference model ----
    m_busy = 1'b0; m_grant = 0; m_last = N - 1; m_txdata = '0;
    rxq.delete();
    p_req = '0; p_clrxack = '0; p_ntack = 1'b0; p_nv = 1'b0; p_nw = '0; p_rxack = 1'b0;
    for (int i = 0; i < N; i++) p_data[i] = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      // transmit expectation
      exp_txack = '0;
      if (m_busy) begin
        if (p_ntack) begin
          exp_txack   = 4'b0001 << m_grant;
          exp_txvalid = 1'b0;
          m_last      = m_grant;
          m_busy      = 1'b0;
        end else begin
          exp_txvalid = 1'b1;
        end
      end else if (p_req != 0) begin
        m_grant     = rr_pick(m_last, p_req);
        m_txdata    = p_data[m_grant];
        m_busy      = 1'b1;
        exp_txvalid = 1'b1;
      end else begin
        exp_txvalid = 1'b0;
      end
      check("rnd_txvalid", node_txvalid, exp_txvalid);
      check("rnd_txack",   cl_txack,     exp_txack);
      if (exp_txvalid) check("rnd_txdata", node_txdata, m_txdata);

      // receive expectation
      exp_rxack = (rxq.size() == 0) && p_nv && !p_rxack;
      check("rnd_rxack", node_rxack, exp_rxack);
      if (rxq.size() != 0) begin
        head = rxq[0];
        ev   = 4'b0001 << head[W-1 -: CB];
        if ((p_clrxack & ev) != 0) void'(rxq.pop_front());
      end
      if (exp_rxack) rxq.push_back(p_nw);
      exp_rxv = '0;
      if (rxq.size() != 0) begin
        head    = rxq[0];
        exp_rxv = 4'b0001 << head[W-1 -: CB];
        check("rnd_rxdata", cl_rxdata, head);
      end
      check("rnd_rxvalid", cl_rxvalid, exp_rxv);

      // drive next inputs
      for (int i = 0; i < N; i++) begin
        if (cl_txreq[i] && cl_txack[i]) begin
          cl_txreq[i] = 1'b0;
        end else if (cl_txreq[i]) begin
          if ($urandom_range(0, 31) == 0) cl_txreq[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          cl_txreq[i] = 1'b1;
          cl_txdata[i*W +: W] = W'($urandom);
        end
      end
      node_txack = ($urandom_range(0, 2) == 0);
      if (node_rxack) begin
        node_rxvalid = ($urandom_range(0, 1) == 0);
        node_rxdata  = W'($urandom);
      end else if (!node_rxvalid) begin
        node_rxvalid = ($urandom_range(0, 2) == 0);
        node_rxdata  = W'($urandom);
      end
      cl_rxack = N'($urandom);

      p_req     = cl_txreq;
      for (int i = 0; i < N; i++) p_data[i] = cl_txdata[i*W +: W];
      p_ntack   = node_txack;
      p_nv      = node_rxvalid;
      p_nw      = node_rxdata;
      p_rxack   = exp_rxack;
      p_clrxack = cl_rxack;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
